// File: rtl/hex_display_ctrl.sv
// Avalon-MM controlled two-digit hex display with a debounced key that can bump VALUE.
// Define HEX_BLINK_EN to build the PERIOD register and the SHOW/BLANK blink logic.
module hex_display_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        key_n,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic        irq
);
    localparam int          DW         = $clog2(DEB_CYCLES);
    localparam logic [23:0] PERIOD_RST = 24'(BLINK_HALF);
`ifdef HEX_BLINK_EN
    localparam logic [3:0]  CTRL_MASK  = 4'hF;
`else
    localparam logic [3:0]  CTRL_MASK  = 4'hD;
`endif

    typedef enum logic [1:0] {OFF, SHOW, BLANK} disp_state_e;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    logic [7:0]    value_q;
    logic [3:0]    ctrl_q;
    logic          status_q;
    logic [23:0]   period_rd;
    logic [31:0]   rd_mux;
    logic          wr_value, wr_ctrl, wr_status;
    logic          blink_go;
    disp_state_e   state_q, state_n;

    logic          unused_ok;
    assign unused_ok = ^{avs_writedata, PERIOD_RST};

    assign wr_value  = avs_write && (avs_address == 2'd0);
    assign wr_ctrl   = avs_write && (avs_address == 2'd1);
    assign wr_status = avs_write && (avs_address == 2'd2);

    // Key path: 2-FF synchroniser, then a run-length debouncer.
    logic [1:0]    key_sync;
    logic [1:0]    vld_pipe;
    logic          key_s, deb_level, deb_done, armed, press;
    logic [DW-1:0] deb_cnt;

    assign key_s    = key_sync[1];
    assign deb_done = (deb_cnt == DW'(DEB_CYCLES - 1));
    // armed blocks the event from a key already held down when reset released
    assign press    = vld_pipe[1] && armed && deb_level && !key_s && deb_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_sync  <= 2'b11;
            vld_pipe  <= '0;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            armed     <= 1'b0;
        end else begin
            key_sync <= {key_sync[0], key_n};
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1]) begin
                if (key_s && deb_level)
                    armed <= 1'b1;
                if (key_s == deb_level)
                    deb_cnt <= '0;
                else if (deb_done) begin
                    deb_level <= key_s;
                    deb_cnt   <= '0;
                end else
                    deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0:    rd_mux[7:0]  = value_q;
            2'd1:    rd_mux[3:0]  = ctrl_q;
            2'd2:    rd_mux[0]    = status_q;
            default: rd_mux[23:0] = period_rd;
        endcase
    end

    // CPU write to VALUE beats a key increment; a press event beats a STATUS clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q      <= '0;
            ctrl_q       <= '0;
            status_q     <= 1'b0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (wr_value)
                value_q <= avs_writedata[7:0];
            else if (press && ctrl_q[2])
                value_q <= value_q + 8'd1;
            if (wr_ctrl)
                ctrl_q <= avs_writedata[3:0] & CTRL_MASK;
            if (press)
                status_q <= 1'b1;
            else if (wr_status && avs_writedata[0])
                status_q <= 1'b0;
            irq <= status_q & ctrl_q[3];
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

`ifdef HEX_BLINK_EN
    logic [23:0] period_q, blink_cnt, blink_last;
    logic        wr_period, blink_tick;

    assign wr_period  = avs_write && (avs_address == 2'd3);
    assign period_rd  = period_q;
    assign blink_last = (period_q == 24'd0) ? 24'd0 : period_q - 24'd1;
    assign blink_tick = (blink_cnt == blink_last);
    assign blink_go   = ctrl_q[1] && blink_tick;

    always_ff @(posedge clk) begin
        if (!reset_n)
            period_q <= PERIOD_RST;
        else if (wr_period)
            period_q <= avs_writedata[23:0];
    end

    // phase counter only runs while the display is up and blinking
    always_ff @(posedge clk) begin
        if (!reset_n || wr_ctrl || wr_period)
            blink_cnt <= '0;
        else if (state_q != OFF && ctrl_q[0] && ctrl_q[1])
            blink_cnt <= blink_tick ? 24'd0 : blink_cnt + 24'd1;
        else
            blink_cnt <= '0;
    end
`else
    assign period_rd = '0;
    assign blink_go  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= OFF;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            OFF:     if (ctrl_q[0]) state_n = SHOW;
            SHOW:    if (!ctrl_q[0]) state_n = OFF;
                     else if (blink_go) state_n = BLANK;
            BLANK:   if (!ctrl_q[0]) state_n = OFF;
                     else if (!ctrl_q[1] || blink_go) state_n = SHOW;
            default: state_n = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hex0 <= 7'h7F;
            hex1 <= 7'h7F;
        end else if (state_n == SHOW) begin
            hex0 <= seg7(value_q[3:0]);
            hex1 <= seg7(value_q[7:4]);
        end else begin
            hex0 <= 7'h7F;
            hex1 <= 7'h7F;
        end
    end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised bench for hex_display_ctrl against a cycle-level behavioural model.
module tb_hex_display_ctrl;
    localparam int DEB = 4;
    localparam int BH  = 8;
    localparam int M_OFF = 0, M_SHOW = 1, M_BLANK = 2;
`ifdef HEX_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        key_n = 1'b1;
    logic [6:0]  hex0, hex1;
    logic        irq;

    hex_display_ctrl #(.DEB_CYCLES(DEB), .BLINK_HALF(BH)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .key_n(key_n), .hex0(hex0), .hex1(hex1), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: register file, key history, display mode and phase age.
    int m_value, m_ctrl, m_status, m_period, m_irq, m_hex0, m_hex1, m_rd;
    bit m_rd_vld;
    int m_k0, m_k1, m_fill, m_level, m_run, m_armed;
    int m_mode, m_age;

    always @(posedge clk) begin : model
        int ks, per, mode_n, wd;
        bit press, wv, wc, ws, wp, blinking;
        if (!reset_n) begin
            m_value = 0; m_ctrl = 0; m_status = 0; m_period = BH; m_irq = 0;
            m_hex0 = 'h7F; m_hex1 = 'h7F; m_rd = 0; m_rd_vld = 0;
            m_k0 = 1; m_k1 = 1; m_fill = 0; m_level = 1; m_run = 0; m_armed = 0;
            m_mode = M_OFF; m_age = 0;
        end else begin
            wd = int'(avs_writedata);
            wv = avs_write && avs_address == 2'd0;
            wc = avs_write && avs_address == 2'd1;
            ws = avs_write && avs_address == 2'd2;
            wp = avs_write && avs_address == 2'd3;
            // key: a level is accepted after DEB consecutive disagreeing samples
            press = 1'b0;
            ks = m_k1;
            if (m_fill >= 2) begin
                if (ks == 1 && m_level == 1) m_armed = 1;
                if (ks != m_level) begin
                    m_run++;
                    if (m_run == DEB) begin
                        press = (ks == 0) && (m_armed == 1);
                        m_level = ks;
                        m_run = 0;
                    end
                end else m_run = 0;
            end
            m_k1 = m_k0;
            m_k0 = key_n ? 1 : 0;
            if (m_fill < 2) m_fill++;
            // outputs derived from the register values before this edge
            m_rd_vld = avs_read;
            if (avs_read) begin
                case (avs_address)
                    2'd0: m_rd = m_value;
                    2'd1: m_rd = m_ctrl;
                    2'd2: m_rd = m_status;
                    default: m_rd = BLINK ? m_period : 0;
                endcase
            end
            m_irq = m_status & ((m_ctrl >> 3) & 1);
            per = (m_period == 0) ? 1 : m_period;
            blinking = BLINK && m_mode != M_OFF && (m_ctrl & 3) == 3;
            mode_n = m_mode;
            if ((m_ctrl & 1) == 0) mode_n = M_OFF;
            else if (m_mode == M_OFF || (m_ctrl & 2) == 0) mode_n = M_SHOW;
            else if (blinking && m_age == per - 1) mode_n = (m_mode == M_SHOW) ? M_BLANK : M_SHOW;
            if (wc || (wp && BLINK)) m_age = 0;
            else if (blinking) m_age = (m_age == per - 1) ? 0 : m_age + 1;
            else m_age = 0;
            m_hex0 = (mode_n == M_SHOW) ? int'(glyph[m_value & 15]) : 'h7F;
            m_hex1 = (mode_n == M_SHOW) ? int'(glyph[(m_value >> 4) & 15]) : 'h7F;
            m_mode = mode_n;
            if (wv) m_value = wd & 'hFF;
            else if (press && (m_ctrl & 4) != 0) m_value = (m_value + 1) % 256;
            if (press) m_status = 1;
            else if (ws && (wd & 1) != 0) m_status = 0;
            if (wc) m_ctrl = wd & (BLINK ? 'hF : 'hD);
            if (wp && BLINK) m_period = wd & 'hFFFFFF;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hex0", 32'(hex0), 32'(m_hex0));
            check("hex1", 32'(hex1), 32'(m_hex1));
            check("irq", 32'(irq), 32'(m_irq));
            if (m_rd_vld) check("readdata", avs_readdata, 32'(m_rd));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic press_key();
        @(negedge clk); key_n = 1'b0;
        cycles(8);
        key_n = 1'b1;
        cycles(10);
    endtask

    initial begin
        logic [31:0] d;
        int key_hold;
        reset_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cycles(2);
        check("rst_hex0", 32'(hex0), 32'h7F);
        check("rst_hex1", 32'(hex1), 32'h7F);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        cycles(3);

        // VALUE/CTRL decode and read latency
        wr(2'd0, 32'h1A);
        wr(2'd1, 32'h1);
        check("hex_pre_show", 32'(hex0), 32'h7F);
        cycles(1);
        check("hex1_1", 32'(hex1), 32'h79);
        check("hex0_A", 32'(hex0), 32'h08);
        rd(2'd0, d);
        check("rd_value_1A", d, 32'h1A);

        // glitch then a real press, with wrap from 0xFF
        wr(2'd1, 32'h5);
        wr(2'd0, 32'hFF);
        @(negedge clk); key_n = 1'b0;
        cycles(2); key_n = 1'b1;
        cycles(2); key_n = 1'b0;
        cycles(10); key_n = 1'b1;
        cycles(10);
        rd(2'd0, d);
        check("wrap_value", d, 32'h00);
        rd(2'd2, d);
        check("status_set", d, 32'h1);
        check("hex0_0", 32'(hex0), 32'h40);

        // interrupt set, clear and mask
        wr(2'd2, 32'h1);
        wr(2'd1, 32'hD);
        press_key();
        check("irq_on", 32'(irq), 32'h1);
        wr(2'd2, 32'h1);
        check("irq_lag", 32'(irq), 32'h1);
        cycles(1);
        check("irq_clr", 32'(irq), 32'h0);
        press_key();
        check("irq_on2", 32'(irq), 32'h1);
        wr(2'd1, 32'h5);
        cycles(1);
        check("irq_masked", 32'(irq), 32'h0);
        rd(2'd2, d);
        check("status_sticky", d, 32'h1);

        // CPU VALUE write lands on the same edge as the key increment
        wr(2'd2, 32'h1);
        @(negedge clk); key_n = 1'b0;
        cycles(4);
        wr(2'd0, 32'h42);
        cycles(6); key_n = 1'b1;
        cycles(10);
        rd(2'd0, d);
        check("coincident_value", d, 32'h42);
        rd(2'd2, d);
        check("coincident_status", d, 32'h1);
        // STATUS clear on the same edge as a press event
        wr(2'd2, 32'h1);
        @(negedge clk); key_n = 1'b0;
        cycles(4);
        wr(2'd2, 32'h1);
        cycles(6); key_n = 1'b1;
        cycles(10);
        rd(2'd2, d);
        check("clear_vs_press", d, 32'h1);
        rd(2'd0, d);
        check("value_inc_43", d, 32'h43);

`ifdef HEX_BLINK_EN
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h1A);
        wr(2'd1, 32'h3);
        cycles(1);
        check("blink_show_first", 32'(hex0), 32'h08);
        cycles(7);
        check("blink_show_last", 32'(hex0), 32'h08);
        cycles(1);
        check("blink_blank", 32'(hex0), 32'h7F);
        wr(2'd1, 32'h1);
        check("unblink_lag", 32'(hex0), 32'h7F);
        cycles(1);
        check("unblink_show", 32'(hex0), 32'h08);
        wr(2'd3, 32'h0);
        wr(2'd1, 32'h3);
        cycles(12);
        rd(2'd3, d);
        check("period_rd", d, 32'h0);
        wr(2'd3, 32'd3);
        cycles(20);
`else
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h1A);
        wr(2'd1, 32'h3);
        cycles(64);
        check("steady_glyph", 32'(hex0), 32'h08);
        rd(2'd1, d);
        check("ctrl_no_blink", d, 32'h1);
        wr(2'd3, 32'h5);
        rd(2'd3, d);
        check("period_zero", d, 32'h0);
`endif

        // reset in the middle of a debounce, key still held at release
        @(negedge clk); key_n = 1'b0;
        cycles(3);
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(12);
        key_n = 1'b1;
        cycles(10);
        rd(2'd2, d);
        check("no_event_after_reset", d, 32'h0);
        wr(2'd1, 32'h5);
        press_key();
        rd(2'd2, d);
        check("event_after_reset", d, 32'h1);
        rd(2'd0, d);
        check("value_after_reset", d, 32'h1);

        // random traffic
        key_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            avs_write = ($urandom_range(0, 4) == 0);
            avs_read = ($urandom_range(0, 3) == 0);
            avs_address = 2'($urandom_range(0, 3));
            avs_writedata = $urandom();
            if (avs_address == 2'd3) avs_writedata = $urandom_range(0, 12);
            if (key_hold == 0) begin
                key_n = ~key_n;
                key_hold = $urandom_range(1, 12);
            end else key_hold--;
            reset_n = ($urandom_range(0, 799) != 0);
        end
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0; reset_n = 1'b1;
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
